// File: rtl/kyber_compress_if.sv
// Stream interface for kyber_compress: one input beat of eight 12-bit
// coefficients plus its compression width, and one output beat carrying
// the packed codes for d = 1, 4 and 10 with sideband flags.
interface kyber_compress_if;
    logic [3:0]  d;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data_d1;
    logic [31:0] out_data_d4;
    logic [79:0] out_data_d10;
    logic [3:0]  out_d;
    logic        out_err;
    logic        out_last;

    modport master (
        output d, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data_d1, out_data_d4, out_data_d10,
               out_d, out_err, out_last
    );

    modport slave (
        input  d, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data_d1, out_data_d4, out_data_d10,
               out_d, out_err, out_last
    );
endinterface

// File: rtl/kyber_compress.sv
// Kyber Compress_q(x,d) for d in {1,4,10}, eight lanes per beat.
// Stage 1 forms n = (x<<d) + (q-1)/2, stage 2 divides by q with a Barrett
// multiply and keeps the low d bits. A 5-bit counter marks the last beat
// of each 256-coefficient polynomial.
module kyber_compress (
    input logic             clk,
    input logic             rst_n,
    kyber_compress_if.slave bus
);
    localparam int          Q      = 3329;
    localparam logic [22:0] HALF_Q = 23'((Q - 1) / 2);
    localparam logic [44:0] BARR_M = 45'd2580335;
    localparam int          BARR_K = 33;
    localparam int          NBEATS = 32;

    // n is 23 bits wide so that x up to 4095 at d=10 still rounds correctly;
    // Barrett with this multiplier stays exact for every n below 2^23.
    logic        en;
    logic        legal_in;
    logic [22:0] n_next [8];

    logic        s1_valid;
    logic        s1_err;
    logic [3:0]  s1_d;
    logic [22:0] s1_n [8];

    logic [9:0]  code [8];
    logic [7:0]  d1_next;
    logic [31:0] d4_next;
    logic [79:0] d10_next;

    logic        s2_valid;
    logic        s2_err;
    logic [3:0]  s2_d;
    logic [7:0]  s2_d1;
    logic [31:0] s2_d4;
    logic [79:0] s2_d10;
    logic [4:0]  beat_cnt;

    assign en       = ~s2_valid | bus.out_ready;
    assign legal_in = (bus.d == 4'd1) | (bus.d == 4'd4) | (bus.d == 4'd10);

    // Stage 1 datapath: shift each coefficient by d and add the rounding half-modulus.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            n_next[i] = '0;
            case (bus.d)
                4'd1:    n_next[i] = {10'b0, bus.in_data[12*i +: 12], 1'b0} + HALF_Q;
                4'd4:    n_next[i] = {7'b0, bus.in_data[12*i +: 12], 4'b0} + HALF_Q;
                4'd10:   n_next[i] = {1'b0, bus.in_data[12*i +: 12], 10'b0} + HALF_Q;
                default: n_next[i] = '0;
            endcase
        end
    end

    // Stage 2 datapath: Barrett quotient per lane, packed into the field chosen by d.
    always_comb begin
        d1_next  = '0;
        d4_next  = '0;
        d10_next = '0;
        for (int i = 0; i < 8; i++) begin
            code[i] = 10'(({22'b0, s1_n[i]} * BARR_M) >> BARR_K);
            case (s1_d)
                4'd1:    d1_next[i]           = code[i][0];
                4'd4:    d4_next[4*i +: 4]    = code[i][3:0];
                4'd10:   d10_next[10*i +: 10] = code[i];
                default: ;
            endcase
        end
    end

    // Pipeline registers advance together on en; the beat counter steps on each output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_d     <= '0;
            for (int i = 0; i < 8; i++) begin
                s1_n[i] <= '0;
            end
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_d     <= '0;
            s2_d1    <= '0;
            s2_d4    <= '0;
            s2_d10   <= '0;
            beat_cnt <= '0;
        end else begin
            if (en) begin
                s1_valid <= bus.in_valid;
                s1_err   <= ~legal_in;
                s1_d     <= bus.d;
                for (int i = 0; i < 8; i++) begin
                    s1_n[i] <= n_next[i];
                end
                s2_valid <= s1_valid;
                s2_err   <= s1_err;
                s2_d     <= s1_d;
                s2_d1    <= d1_next;
                s2_d4    <= d4_next;
                s2_d10   <= d10_next;
            end
            if (s2_valid && bus.out_ready) begin
                beat_cnt <= beat_cnt + 5'd1;
            end
        end
    end

    assign bus.in_ready     = rst_n & en;
    assign bus.out_valid    = s2_valid;
    assign bus.out_data_d1  = s2_d1;
    assign bus.out_data_d4  = s2_d4;
    assign bus.out_data_d10 = s2_d10;
    assign bus.out_d        = s2_d;
    assign bus.out_err      = s2_err;
    assign bus.out_last     = s2_valid & (beat_cnt == 5'(NBEATS - 1));
endmodule

// File: tb/tb_kyber_compress.sv
// Directed bench for kyber_compress: hand-computed vectors, exhaustive sweep
// against the integer rounding formula, back-pressure, illegal d and reset.
module tb_kyber_compress;
    typedef struct packed {
        logic [7:0]  d1;
        logic [31:0] d4;
        logic [79:0] d10;
        logic [3:0]  d;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    kyber_compress_if bus ();

    kyber_compress dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total;
    int   bad;
    int   beat_in_poly;
    int   out_seen;
    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the bench can never hang.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int ref_code(input int x, input int dd);
        return (((x << dd) + 1664) / 3329) % (1 << dd);
    endfunction

    function automatic exp_t make_exp(input logic [3:0] dd, input logic [95:0] data);
        exp_t       e;
        logic [9:0] c;
        e     = '0;
        e.d   = dd;
        e.err = !(dd == 4'd1 || dd == 4'd4 || dd == 4'd10);
        if (!e.err) begin
            for (int i = 0; i < 8; i++) begin
                c = 10'(ref_code(int'(data[12*i +: 12]), int'(dd)));
                case (dd)
                    4'd1:    e.d1[i]           = c[0];
                    4'd4:    e.d4[4*i +: 4]    = c[3:0];
                    default: e.d10[10*i +: 10] = c;
                endcase
            end
        end
        return e;
    endfunction

    task automatic check_field(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_output(input logic ordy);
        exp_t e;
        if (bus.out_valid && ordy) begin
            if (q.size() == 0) begin
                check_field("unexpected_beat", 80'd1, 80'd0);
            end else begin
                e = q.pop_front();
                check_field("out_data_d1", 80'(bus.out_data_d1), 80'(e.d1));
                check_field("out_data_d4", 80'(bus.out_data_d4), 80'(e.d4));
                check_field("out_data_d10", bus.out_data_d10, e.d10);
                check_field("out_d", 80'(bus.out_d), 80'(e.d));
                check_field("out_err", 80'(bus.out_err), 80'(e.err));
                check_field("out_last", 80'(bus.out_last), 80'(beat_in_poly == 31));
                beat_in_poly = (beat_in_poly + 1) % 32;
                out_seen++;
            end
        end
        if (bus.out_valid && !ordy) check_field("stall_in_ready", 80'(bus.in_ready), 80'd0);
        if (!bus.out_valid) check_field("idle_in_ready", 80'(bus.in_ready), 80'd1);
    endtask

    task automatic apply_stimulus(input logic v, input logic [3:0] dd, input logic [95:0] data,
                                  input exp_t e, input logic ordy, output logic acc);
        bus.in_valid  = v;
        bus.d         = dd;
        bus.in_data   = data;
        bus.out_ready = ordy;
        @(negedge clk);
        check_output(ordy);
        acc = v && bus.in_ready;
        if (acc) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            apply_stimulus(1'b0, 4'd0, '0, '0, 1'b1, acc);
        end
        check_field("drain_empty", 80'(q.size()), 80'd0);
        q.delete();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.d         = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_field("rst_out_valid", 80'(bus.out_valid), 80'd0);
        check_field("rst_in_ready", 80'(bus.in_ready), 80'd0);
        check_field("rst_d1", 80'(bus.out_data_d1), 80'd0);
        check_field("rst_d4", 80'(bus.out_data_d4), 80'd0);
        check_field("rst_d10", bus.out_data_d10, 80'd0);
        check_field("rst_flags", 80'({bus.out_d, bus.out_err, bus.out_last}), 80'd0);
        rst_n = 1'b1;
        #1;
        check_field("post_rst_in_ready", 80'(bus.in_ready), 80'd1);
        q.delete();
        beat_in_poly = 0;
    endtask

    initial begin
        logic [95:0] data;
        logic [3:0]  dd;
        logic        acc;
        logic        ordy;
        exp_t        e;
        int          base;
        int          sent;
        int          stall_left;
        logic        st5;
        logic        st31;

        total        = 0;
        bad          = 0;
        out_seen     = 0;
        beat_in_poly = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.d        = '0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        do_reset();

        // Directed vectors, lanes listed from lane 7 down to lane 0.
        data = {12'd3328, 12'd1665, 12'd1664, 12'd0, 12'd2497, 12'd2496, 12'd833, 12'd832};
        e = '0; e.d = 4'd1; e.d1 = 8'h66;
        apply_stimulus(1'b1, 4'd1, data, e, 1'b1, acc);
        data = {12'd2913, 12'd105, 12'd104, 12'd3328, 12'd3121, 12'd1665, 12'd208, 12'd0};
        e = '0; e.d = 4'd4; e.d4 = 32'hE100F810;
        apply_stimulus(1'b1, 4'd4, data, e, 1'b1, acc);
        data = {12'd4095, 12'd1664, 12'd3327, 12'd3328, 12'd1665, 12'd2, 12'd1, 12'd0};
        e = '0; e.d = 4'd10;
        e.d10 = {10'd236, 10'd512, 10'd1023, 10'd0, 10'd512, 10'd1, 10'd0, 10'd0};
        apply_stimulus(1'b1, 4'd10, data, e, 1'b1, acc);
        drain();

        // Round trip: decompress(d=4,k) = round(k*q/16) must compress back to k.
        for (int b = 0; b < 2; b++) begin
            e = '0; e.d = 4'd4;
            for (int i = 0; i < 8; i++) begin
                data[12*i +: 12] = 12'(((b * 8 + i) * 3329 + 8) / 16);
                e.d4[4*i +: 4]   = 4'(b * 8 + i);
            end
            apply_stimulus(1'b1, 4'd4, data, e, 1'b1, acc);
        end
        drain();

        // Exhaustive sweep of every 12-bit x for each legal d.
        for (int k = 0; k < 3; k++) begin
            dd = (k == 0) ? 4'd1 : (k == 1) ? 4'd4 : 4'd10;
            for (int b = 0; b < 512; b++) begin
                for (int i = 0; i < 8; i++) data[12*i +: 12] = 12'(b * 8 + i);
                apply_stimulus(1'b1, dd, data, make_exp(dd, data), 1'b1, acc);
            end
        end
        drain();

        // Back-pressure: 40 beats, 3-cycle stalls at output beats 5 and 31.
        do_reset();
        base = out_seen; sent = 0; stall_left = 0; st5 = 1'b0; st31 = 1'b0;
        for (int c = 0; c < 300 && (out_seen - base) < 40; c++) begin
            ordy = 1'b1;
            if (stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end else if (bus.out_valid && (out_seen - base) == 4 && !st5) begin
                ordy = 1'b0; stall_left = 2; st5 = 1'b1;
            end else if (bus.out_valid && (out_seen - base) == 30 && !st31) begin
                ordy = 1'b0; stall_left = 2; st31 = 1'b1;
            end
            dd = (sent % 3 == 0) ? 4'd10 : (sent % 3 == 1) ? 4'd4 : 4'd1;
            for (int i = 0; i < 8; i++) data[12*i +: 12] = 12'($urandom_range(0, 4095));
            apply_stimulus(sent < 40, dd, data, make_exp(dd, data), ordy, acc);
            if (acc) sent++;
        end
        check_field("bp_beats_out", 80'(out_seen - base), 80'd40);
        check_field("bp_stalls_seen", 80'({st5, st31}), 80'b11);
        drain();

        // Illegal d sandwiched between d=10 beats.
        do_reset();
        data = {12'd4095, 12'd1664, 12'd3327, 12'd3328, 12'd1665, 12'd2, 12'd1, 12'd0};
        apply_stimulus(1'b1, 4'd10, data, make_exp(4'd10, data), 1'b1, acc);
        e = '0; e.d = 4'd7; e.err = 1'b1;
        apply_stimulus(1'b1, 4'd7, data, e, 1'b1, acc);
        apply_stimulus(1'b1, 4'd10, data, make_exp(4'd10, data), 1'b1, acc);
        drain();

        // Reset with two beats in flight.
        apply_stimulus(1'b1, 4'd4, data, make_exp(4'd4, data), 1'b1, acc);
        apply_stimulus(1'b1, 4'd1, data, make_exp(4'd1, data), 1'b1, acc);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_field("midrst_out_valid", 80'(bus.out_valid), 80'd0);
        do_reset();

        // Counter restarts at zero: out_last must land on the 32nd beat.
        base = out_seen;
        for (int b = 0; b < 32; b++) begin
            dd = (b % 2 == 0) ? 4'd4 : 4'd10;
            for (int i = 0; i < 8; i++) data[12*i +: 12] = 12'($urandom_range(0, 4095));
            apply_stimulus(1'b1, dd, data, make_exp(dd, data), 1'b1, acc);
        end
        drain();
        check_field("restart_beats_out", 80'(out_seen - base), 80'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
